// File: rtl/sum_result_buffer.sv
// First-word-fall-through FIFO that captures adder sums, absorbs bursts, flags drops and reports fill level.
// Optional running accumulator of accepted sums: define SUM_BUF_ACCUM_EN.
module sum_result_buffer #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
`ifdef SUM_BUF_ACCUM_EN
  ,
  parameter int ACC_W = 24
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             ovf,
  input  logic             clr_ovf
`ifdef SUM_BUF_ACCUM_EN
  ,
  output logic [ACC_W-1:0] acc,
  input  logic             clr_acc
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             drop;

  assign full      = (level == LVL_W'(DEPTH));
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && full && !pop;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      // Set wins over a same-cycle clear so no drop goes unreported.
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset; out_valid masks stale entries, so clearing it would only cost area.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

`ifdef SUM_BUF_ACCUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (push) begin
      acc <= (clr_acc ? '0 : acc) + {{(ACC_W - W){1'b0}}, in_data};
    end else if (clr_acc) begin
      acc <= '0;
    end
  end
`endif

endmodule
